fractional_baud_generator: RTL
==============================

FRACTIONAL_BAUD_GENERATOR -- requirements
Module: fractional_baud_generator

Interface
REQ-001 Parameter SYSTEM_CLK, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200: reset-time baud rate.
REQ-003 Parameter OVERSAMPLE, default 16: os_tick pulses per bit; legal range 4..64.
REQ-004 Parameter DIV_W, default 16: width of the integer divisor.
REQ-005 Parameter FRAC_W, default 8: width of the fractional divisor.
REQ-006 Port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-007 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port en, input, 1 bit: tick generation enable.
REQ-009 Port resync, input, 1 bit: single-cycle pulse that restarts bit timing, e.g. on an RX start-bit edge.
REQ-010 Port cfg_valid, input, 1 bit: a new divisor is offered.
REQ-011 Port cfg_div_int, input, DIV_W bits: integer part of the clocks-per-os_tick divisor.
REQ-012 Port cfg_div_frac, input, FRAC_W bits: fractional part of that divisor.
REQ-013 Port cfg_ready, output, 1 bit: high when no divisor update is pending.
REQ-014 Port cfg_err, output, 1 bit: one-cycle pulse when an offered divisor is rejected.
REQ-015 Port os_tick, output, 1 bit: one-cycle pulse at the oversample rate.
REQ-016 Port bit_tick, output, 1 bit: one-cycle pulse once per OVERSAMPLE os_ticks.
REQ-017 Port baud_clk, output, 1 bit: square wave that toggles on every os_tick, for legacy consumers.

Function
REQ-018 The effective divisor D = div_int + div_frac/2^FRAC_W; the mean os_tick period SHALL equal D clocks.
REQ-019 Period generation SHALL work as follows:
- An FRAC_W-bit accumulator adds div_frac at each os_tick.
- On carry-out of that add, the next period is div_int+1 clocks; otherwise it is div_int clocks.
REQ-020 A down-counter SHALL load (period-1) and assert os_tick during the cycle it reads 0, while en=1.
REQ-021 os_cnt, range 0..OVERSAMPLE-1, SHALL increment on each os_tick and wrap to 0.
REQ-022 bit_tick SHALL assert in the same cycle as the os_tick on which os_cnt=OVERSAMPLE-1.
REQ-023 The enable SHALL behave as follows:
- With en=0, the counter, accumulator and os_cnt hold their values.
- With en=0, os_tick and bit_tick stay 0.
- With en=1, counting resumes from the held state.
REQ-024 A config transfer SHALL occur when cfg_valid=1 and cfg_ready=1 in the same cycle.
REQ-025 An accepted divisor SHALL be held pending, and cfg_ready SHALL be 0 while it is pending.
REQ-026 A pending divisor SHALL take effect as follows:
- It is applied at the next os_tick, and that os_tick's reload uses the new value.
- If en=0 or resync=1, it is applied in the next cycle instead.
- After it is applied, cfg_ready returns to 1.
REQ-027 A divisor with div_int<2 SHALL be rejected:
- cfg_err pulses in the cycle after the transfer.
- The transfer is consumed.
- The current divisor is unchanged and cfg_ready stays 1.
REQ-028 resync=1 SHALL perform the following in the next cycle:
- Clear the accumulator.
- Load the counter with (div_int-1).
- Set os_cnt to OVERSAMPLE/2, so that bit_tick lands at mid-bit.
- Suppress any os_tick in the resync cycle.
REQ-029 resync SHALL take priority over a coincident os_tick; en=0 with resync=1 still performs the reload.
REQ-030 baud_clk SHALL toggle on every os_tick and hold otherwise; its period is 2D clocks.

Reset
REQ-031 While reset_n=0, the following SHALL hold:
- os_tick=0, bit_tick=0, baud_clk=0, cfg_err=0 and cfg_ready=1.
- The accumulator=0, os_cnt=0, and no divisor is pending.
REQ-032 During reset, the divisor SHALL be set from RST_DIV = (SYSTEM_CLK*2^FRAC_W)/(BAUD_RATE*OVERSAMPLE), integer division:
- div_int takes the upper bits of RST_DIV.
- div_frac takes the low FRAC_W bits; for the defaults this gives 27 + 32/256.
- The counter is loaded with div_int-1.
REQ-033 Deasserting reset_n SHALL be safe at any point, including mid-transfer; a pending config is discarded.

Structure
REQ-034 The shared package baud_pkg SHALL hold:
- The RST_DIV computation function.
- The minimum div_int constant, 2.
- The OVERSAMPLE legality check.
REQ-035 The design SHALL be a single module with no sub-modules; the accumulator and counter are inline.

Verification
REQ-036 Default parameters, en=1 for 256 os_ticks -> intervals are 27 or 28 clocks, exactly 32 of them are 28 clocks, and the total is 6944 clocks.
REQ-037 cfg_div_int=10, cfg_div_frac=0 sent mid-period -> cfg_ready low until the next os_tick; thereafter every interval is 10 clocks and bit_tick arrives every 160 clocks.
REQ-038 cfg_div_int=1 -> cfg_err pulses once, cfg_ready stays 1, and the period is unchanged.
REQ-039 resync pulse at an arbitrary cycle -> no os_tick that cycle, the next os_tick is div_int clocks later, and the first bit_tick comes after 8 os_ticks.
REQ-040 en dropped for 50 cycles mid-period -> no ticks during the gap, and the remaining period completes after re-enable.
REQ-041 reset_n asserted with a config pending -> all outputs return to reset values, and RST_DIV timing resumes after release.

Source files
------------

// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the fractional baud generator:
//   - calc_rst_div : reset-time fixed-point divisor (clocks per os_tick,
//                    scaled by 2^frac_w) derived from clock, baud and oversample.
//   - MIN_DIV_INT  : smallest integer divisor the generator accepts.
//   - os_legal     : range check for the OVERSAMPLE parameter.
// -----------------------------------------------------------------------------
package baud_pkg;

    localparam int unsigned MIN_DIV_INT = 32'd2;
    localparam int unsigned OS_MIN      = 32'd4;
    localparam int unsigned OS_MAX      = 32'd64;

    // (sys_clk * 2^frac_w) / (baud * oversample), computed in 64 bits so the
    // scaled numerator cannot overflow for realistic clock frequencies.
    function automatic logic [63:0] calc_rst_div(
        input int unsigned sys_clk,
        input int unsigned baud,
        input int unsigned oversample,
        input int unsigned frac_w
    );
        logic [63:0] num;
        logic [63:0] den;
        num = 64'(sys_clk) << frac_w;
        den = 64'(baud) * 64'(oversample);
        if (den == 64'd0) begin
            calc_rst_div = 64'd0;
        end else begin
            calc_rst_div = num / den;
        end
    endfunction

    function automatic logic os_legal(input int unsigned oversample);
        os_legal = (oversample >= OS_MIN) && (oversample <= OS_MAX);
    endfunction

endpackage

// File: rtl/fractional_baud_generator.sv
// -----------------------------------------------------------------------------
// fractional_baud_generator
// Produces an oversample tick (os_tick) whose mean period is the fractional
// divisor div_int + div_frac/2^FRAC_W clocks, a bit tick every OVERSAMPLE
// os_ticks, and a legacy square wave toggling on each os_tick.
//
// Ports:
//   clk, reset_n       : system clock, asynchronous active-low reset
//   en                 : tick generation enable (state holds while low)
//   resync             : restart bit timing (bit_tick lands at mid-bit)
//   cfg_valid/ready    : divisor offer handshake
//   cfg_div_int/frac   : offered divisor (integer / fractional part)
//   cfg_err            : one-cycle pulse when an offered divisor is rejected
//   os_tick, bit_tick  : one-cycle tick pulses
//   baud_clk           : square wave, period 2 * divisor clocks
// -----------------------------------------------------------------------------
module fractional_baud_generator
    import baud_pkg::*;
#(
    parameter int unsigned SYSTEM_CLK = 32'd50_000_000,
    parameter int unsigned BAUD_RATE  = 32'd115_200,
    parameter int unsigned OVERSAMPLE = 32'd16,
    parameter int unsigned DIV_W      = 32'd16,
    parameter int unsigned FRAC_W     = 32'd8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              resync,
    input  logic              cfg_valid,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              baud_clk
);

    localparam int unsigned       OS_W     = (OVERSAMPLE > 32'd1) ? $clog2(OVERSAMPLE) : 32'd1;
    localparam logic [63:0]       RST_DIV  = calc_rst_div(SYSTEM_CLK, BAUD_RATE, OVERSAMPLE, FRAC_W);
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RST_DIV >> FRAC_W);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV);
    localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(MIN_DIV_INT);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(32'd1);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 32'd1);
    localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 32'd2);
    localparam logic [OS_W-1:0]   OS_ONE   = OS_W'(32'd1);

    generate
        if (!os_legal(OVERSAMPLE)) begin : g_os_illegal
            $error("OVERSAMPLE must lie in 4..64");
        end
    endgenerate

    logic [DIV_W-1:0]  div_int_q,   div_int_d;
    logic [FRAC_W-1:0] div_frac_q,  div_frac_d;
    logic              pend_q,      pend_d;
    logic [DIV_W-1:0]  pend_int_q,  pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic [DIV_W-1:0]  cnt_q,       cnt_d;
    logic [FRAC_W-1:0] acc_q,       acc_d;
    logic [OS_W-1:0]   os_cnt_q,    os_cnt_d;
    logic              baud_q,      baud_d;
    logic              cfg_err_q,   cfg_err_d;

    logic              tick_s;
    logic              apply_s;
    logic [DIV_W-1:0]  use_int_s;
    logic [FRAC_W-1:0] use_frac_s;
    logic [FRAC_W:0]   sum_s;

    // Tick detection and selection of the divisor used by this cycle's reload.
    // A pending divisor is swapped in whenever a reload happens (tick or
    // resync) or the counter is idle (en low), so the reload sees it directly.
    always_comb begin
        tick_s     = en & ~resync & (cnt_q == {DIV_W{1'b0}});
        apply_s    = pend_q & (tick_s | ~en | resync);
        use_int_s  = apply_s ? pend_int_q  : div_int_q;
        use_frac_s = apply_s ? pend_frac_q : div_frac_q;
        sum_s      = {1'b0, acc_q} + {1'b0, use_frac_s};
    end

    // Next-state logic: period counter, phase accumulator, os_cnt, baud_clk,
    // and the divisor handshake.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        os_cnt_d    = os_cnt_q;
        baud_d      = baud_q;
        div_int_d   = div_int_q;
        div_frac_d  = div_frac_q;
        pend_d      = pend_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        cfg_err_d   = 1'b0;

        if (resync) begin
            acc_d    = {FRAC_W{1'b0}};
            cnt_d    = use_int_s - DIV_ONE;
            os_cnt_d = OS_HALF;
        end else if (tick_s) begin
            // Accumulator carry stretches the next period by one clock.
            acc_d    = sum_s[FRAC_W-1:0];
            cnt_d    = sum_s[FRAC_W] ? use_int_s : (use_int_s - DIV_ONE);
            os_cnt_d = (os_cnt_q == OS_LAST) ? {OS_W{1'b0}} : (os_cnt_q + OS_ONE);
            baud_d   = ~baud_q;
        end else if (en) begin
            cnt_d = cnt_q - DIV_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        if (apply_s) begin
            div_int_d  = pend_int_q;
            div_frac_d = pend_frac_q;
            pend_d     = 1'b0;
        end else if (cfg_valid && !pend_q) begin
            if (cfg_div_int < MIN_INT) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_int_d  = cfg_div_int;
                pend_frac_d = cfg_div_frac;
            end
        end else begin
            pend_d = pend_q;
        end
    end

    // State registers; reset loads the parameter-derived divisor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_int_q   <= RST_INT;
            div_frac_q  <= RST_FRAC;
            pend_q      <= 1'b0;
            pend_int_q  <= {DIV_W{1'b0}};
            pend_frac_q <= {FRAC_W{1'b0}};
            cnt_q       <= RST_INT - DIV_ONE;
            acc_q       <= {FRAC_W{1'b0}};
            os_cnt_q    <= {OS_W{1'b0}};
            baud_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            div_int_q   <= div_int_d;
            div_frac_q  <= div_frac_d;
            pend_q      <= pend_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            os_cnt_q    <= os_cnt_d;
            baud_q      <= baud_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign os_tick   = tick_s;
    assign bit_tick  = tick_s & (os_cnt_q == OS_LAST);
    assign baud_clk  = baud_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_ready = ~pend_q;

endmodule
